// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - accumulator width, saturation limit and ReLU/shift/saturate requant shared by conv stages
package conv_pkg;

   function automatic int acc_w(input int data_size);
      return 2 * data_size + 5;
   endfunction

   function automatic logic [63:0] sat_max(input int data_size);
      return (64'd1 << data_size) - 64'd1;
   endfunction

   // Works on a 64-bit sign-extended accumulator so any DATA_SIZE up to 29 can share it
   function automatic logic [63:0] requant(input logic signed [63:0] acc,
                                           input int shift,
                                           input int data_size);
      logic [63:0] v;
      v = (acc < 0) ? 64'd0 : 64'(acc >>> shift);
      return (v > sat_max(data_size)) ? sat_max(data_size) : v;
   endfunction

endpackage

// File: rtl/conv_pool_2x2_if.sv
// rtl/conv_pool_2x2_if.sv - conv accumulator stream in, pooled pixel stream out; pool_bypass only with CONV_POOL_BYPASS_EN
interface conv_pool_2x2_if
   import conv_pkg::*;
#(
   parameter int DATA_SIZE = 8
);
   logic signed [acc_w(DATA_SIZE)-1:0] conv_in;
   logic                               conv_valid;
   logic                               clear;
`ifdef CONV_POOL_BYPASS_EN
   logic                               pool_bypass;
`endif
   logic [DATA_SIZE-1:0]               pool_out;
   logic                               pool_valid;
   logic                               frame_done;

   modport master (
`ifdef CONV_POOL_BYPASS_EN
      output pool_bypass,
`endif
      output conv_in, conv_valid, clear,
      input  pool_out, pool_valid, frame_done
   );

   modport slave (
`ifdef CONV_POOL_BYPASS_EN
      input  pool_bypass,
`endif
      input  conv_in, conv_valid, clear,
      output pool_out, pool_valid, frame_done
   );
endinterface

// File: rtl/conv_requant.sv
// rtl/conv_requant.sv - combinational ReLU, arithmetic right shift and unsigned saturation
module conv_requant
   import conv_pkg::*;
#(
   parameter int DATA_SIZE = 8,
   parameter int SHIFT     = 4
) (
   input  logic signed [acc_w(DATA_SIZE)-1:0] acc,
   output logic [DATA_SIZE-1:0]               q
);
   assign q = DATA_SIZE'(requant(64'(acc), SHIFT, DATA_SIZE));
endmodule

// File: rtl/conv_pool_2x2.sv
// rtl/conv_pool_2x2.sv - requantise conv results then 2x2 stride-2 max pool
// CONV_POOL_BYPASS_EN adds pool_bypass: pass every requantised sample straight through
module conv_pool_2x2
   import conv_pkg::*;
#(
   parameter int DATA_SIZE  = 8,
   parameter int MAP_WIDTH  = 4,
   parameter int MAP_HEIGHT = 4,
   parameter int SHIFT      = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   conv_pool_2x2_if.slave  bus
);
   localparam int COL_W = $clog2(MAP_WIDTH);
   localparam int ROW_W = $clog2(MAP_HEIGHT);
   localparam int LB_D  = MAP_WIDTH / 2;
   localparam int LB_W  = (LB_D > 1) ? $clog2(LB_D) : 1;

   logic [COL_W-1:0]     col;
   logic [ROW_W-1:0]     row;
   logic [DATA_SIZE-1:0] hreg;
   logic [DATA_SIZE-1:0] linebuf [LB_D];
   logic [DATA_SIZE-1:0] q, h, lb_rd, pooled;
   logic [LB_W-1:0]      lb_idx;
   logic                 last_col, last_row, bypass;

   conv_requant #(.DATA_SIZE(DATA_SIZE), .SHIFT(SHIFT)) u_requant (
      .acc (bus.conv_in),
      .q   (q)
   );

`ifdef CONV_POOL_BYPASS_EN
   assign bypass = bus.pool_bypass;
`else
   assign bypass = 1'b0;
`endif

   assign lb_idx   = LB_W'(col >> 1);
   assign lb_rd    = linebuf[lb_idx];
   assign h        = (q > hreg) ? q : hreg;
   assign pooled   = (lb_rd > h) ? lb_rd : h;
   assign last_col = (col == COL_W'(MAP_WIDTH - 1));
   assign last_row = (row == ROW_W'(MAP_HEIGHT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col            <= '0;
         row            <= '0;
         hreg           <= '0;
         for (int i = 0; i < LB_D; i++) linebuf[i] <= '0;
         bus.pool_out   <= '0;
         bus.pool_valid <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.pool_valid <= 1'b0;
         bus.frame_done <= 1'b0;
         if (bus.clear) begin
            col  <= '0;
            row  <= '0;
            hreg <= '0;
         end else if (bus.conv_valid) begin
            // Bypass leaves hreg/linebuf untouched but counters keep frame position
            if (bypass) begin
               bus.pool_out   <= q;
               bus.pool_valid <= 1'b1;
               bus.frame_done <= last_col && last_row;
            end else if (!col[0]) begin
               hreg <= q;
            end else if (!row[0]) begin
               linebuf[lb_idx] <= h;
            end else begin
               bus.pool_out   <= pooled;
               bus.pool_valid <= 1'b1;
               bus.frame_done <= last_col && last_row;
            end
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_conv_pool_2x2.sv
// tb/tb_conv_pool_2x2.sv - directed bench with frame-level pooling model and per-cycle output compare
module tb_conv_pool_2x2;
   import conv_pkg::*;

   localparam int DS    = 8;
   localparam int W     = 4;
   localparam int H     = 4;
   localparam int SH    = 4;
   localparam int ACC_W = acc_w(DS);
   localparam int QMAX  = (1 << DS) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_pool_2x2_if #(.DATA_SIZE(DS)) bus ();

   conv_pool_2x2 #(
      .DATA_SIZE  (DS),
      .MAP_WIDTH  (W),
      .MAP_HEIGHT (H),
      .SHIFT      (SH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int val;
      bit fd;
      int cyc;
   } exp_t;

   exp_t eq[$];
   int   got[$];
   int   grid[H][W];
   int   checks    = 0;
   int   failures  = 0;
   int   cyc       = 0;
   int   n         = 0;
   int   fd_cnt    = 0;
   bit   bypass_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ref_q(input int x);
      int v;
      if (x < 0) return 0;
      v = x / (1 << SH);
      return (v > QMAX) ? QMAX : v;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      repeat (k) tick();
   endtask

   // Model: place q in the frame grid; a finished 2x2 block yields the max of its four cells
   task automatic send(input int x);
      int   r, c, qv;
      exp_t e;
      r  = n / W;
      c  = n % W;
      qv = ref_q(x);
      grid[r][c] = qv;
      e.cyc = cyc + 1;
      if (bypass_on) begin
         e.val = qv;
         e.fd  = (n == W * H - 1);
         eq.push_back(e);
      end else if ((r % 2 == 1) && (c % 2 == 1)) begin
         e.val = max2(max2(grid[r-1][c-1], grid[r-1][c]), max2(grid[r][c-1], grid[r][c]));
         e.fd  = (r == H - 1) && (c == W - 1);
         eq.push_back(e);
      end
      n = (n + 1) % (W * H);
      bus.conv_in    = ACC_W'(x);
      bus.conv_valid = 1'b1;
      tick();
      bus.conv_valid = 1'b0;
   endtask

   task automatic check_basic(input string name);
      int expv[4];
      expv = '{5, 7, 13, 15};
      check({name, "_count"}, got.size(), 4);
      for (int i = 0; i < 4; i++)
         check(name, (i < got.size()) ? got[i] : -1, expv[i]);
   endtask

   always @(negedge clk) begin : cmp
      exp_t e;
      bit   ev;
      ev = (eq.size() > 0) && (eq[0].cyc == cyc);
      check("pool_valid", int'(bus.pool_valid), int'(ev));
      if (bus.pool_valid) got.push_back(int'(bus.pool_out));
      if (bus.frame_done) fd_cnt++;
      if (ev) begin
         e = eq.pop_front();
         check("pool_out", int'(bus.pool_out), e.val);
         check("frame_done", int'(bus.frame_done), int'(e.fd));
      end else begin
         check("frame_done_idle", int'(bus.frame_done), 0);
      end
      if ((eq.size() > 0) && (eq[0].cyc < cyc)) void'(eq.pop_front());
   end

   initial begin
      int relu_frame[16];
      int fd0;
      bus.conv_in    = '0;
      bus.conv_valid = 1'b0;
      bus.clear      = 1'b0;
`ifdef CONV_POOL_BYPASS_EN
      bus.pool_bypass = 1'b0;
`endif

      // Reset and idle
      rst_n = 1'b0;
      idle(3);
      check("rst_pool_out", int'(bus.pool_out), 0);
      check("rst_pool_valid", int'(bus.pool_valid), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_pool_out", int'(bus.pool_out), 0);
         check("idle_pool_valid", int'(bus.pool_valid), 0);
         check("idle_frame_done", int'(bus.frame_done), 0);
      end

      // Basic back-to-back frame
      got.delete();
      fd0 = fd_cnt;
      for (int k = 0; k < 16; k++) send(16 * k);
      idle(3);
      check_basic("basic");
      check("basic_fd_count", fd_cnt - fd0, 1);

      // ReLU and saturation
      relu_frame = '{-100, 32, 0, 0, 5000, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      got.delete();
      for (int k = 0; k < 16; k++) send(relu_frame[k]);
      idle(3);
      check("relu_count", got.size(), 4);
      check("relu_sat", (got.size() > 0) ? got[0] : -1, 255);

      // Gapped input
      got.delete();
      for (int k = 0; k < 16; k++) begin
         send(16 * k);
         idle($urandom_range(0, 3));
      end
      idle(3);
      check_basic("gapped");

      // clear mid-frame drops the coincident sample
      for (int k = 0; k < 5; k++) send(16 * k);
      bus.clear      = 1'b1;
      bus.conv_in    = ACC_W'(999);
      bus.conv_valid = 1'b1;
      n = 0;
      tick();
      bus.clear      = 1'b0;
      bus.conv_valid = 1'b0;
      got.delete();
      fd0 = fd_cnt;
      for (int k = 0; k < 16; k++) send(16 * k);
      idle(3);
      check_basic("clear");
      check("clear_fd_count", fd_cnt - fd0, 1);

      // Async reset mid-frame
      for (int k = 0; k < 9; k++) send(16 * k);
      check("pre_rst_pool_out", int'(bus.pool_out), 7);
      rst_n = 1'b0;
      #1;
      check("async_rst_pool_out", int'(bus.pool_out), 0);
      check("async_rst_pool_valid", int'(bus.pool_valid), 0);
      #4;
      rst_n = 1'b1;
      n = 0;
      eq.delete();
      tick();
      got.delete();
      for (int k = 0; k < 16; k++) send(16 * k);
      idle(3);
      check_basic("post_rst");

`ifdef CONV_POOL_BYPASS_EN
      bypass_on       = 1'b1;
      bus.pool_bypass = 1'b1;
      got.delete();
      for (int k = 0; k < 16; k++) send(16 * k);
      idle(3);
      check("bypass_count", got.size(), 16);
      for (int i = 0; i < 16; i++)
         check("bypass_val", (i < got.size()) ? got[i] : -1, i);
      bypass_on       = 1'b0;
      bus.pool_bypass = 1'b0;
`endif

      check("drain_queue_empty", eq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv_pool_2x2.md
Name: conv_pool_2x2

Overview:
- Downstream of the 2x2 convolution stage; consumes its raw signed accumulator stream (result plus window-valid qualifier).
- Applies ReLU, then requantises by arithmetic right shift with saturation to DATA_SIZE bits.
- Performs 2x2 stride-2 max pooling using a half-width line buffer; emits one pooled pixel per 2x2 block, raster order.
- No backpressure: the convolution stage cannot stall.

Parameters:
- DATA_SIZE, 8, output pixel width; input width is 2*DATA_SIZE+5.
- MAP_WIDTH, 4, convolution-map columns per row; must be even and >= 2.
- MAP_HEIGHT, 4, convolution-map rows per frame; must be even and >= 2.
- SHIFT, 4, requantisation right-shift amount, 0 .. 2*DATA_SIZE.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- conv_in  in  2*DATA_SIZE+5  signed two's-complement convolution result.
- conv_valid  in  1  conv_in is valid this cycle; no ready signal exists.
- clear  in  1  synchronous frame restart: zeroes counters and drops any partial block.
- pool_out  out  DATA_SIZE  unsigned pooled pixel.
- pool_valid  out  1  one-cycle qualifier for pool_out.
- frame_done  out  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Behaviour:
- Reset (rst_n=0, async): pool_out=0, pool_valid=0, frame_done=0, col=0, row=0, line buffer=0, pending-max register=0.
- Requant (combinational on accepted sample):
  - v = (conv_in < 0) ? 0 : conv_in >>> SHIFT.
  - q = (v > 2^DATA_SIZE-1) ? 2^DATA_SIZE-1 : v[DATA_SIZE-1:0].
- Counters advance only when conv_valid=1:
  - col runs 0..MAP_WIDTH-1, then wraps to 0 and increments row.
  - row runs 0..MAP_HEIGHT-1, then wraps to 0.
  - Idle cycles (conv_valid=0) hold all state; gaps of any length between samples are legal.
- Even col: hreg <= q.
- Odd col: h = max(hreg, q).
  - Even row: linebuf[col>>1] <= h.
  - Odd row: pool_out <= max(linebuf[col>>1], h); pool_valid <= 1 on the next edge.
- Latency: pool_valid rises exactly 1 cycle after the 4th sample of a block is accepted. Outputs are registered; pool_valid is otherwise 0.
- frame_done=1 in the same cycle as pool_valid for block (row=MAP_HEIGHT-1, col=MAP_WIDTH-1).
- Output rate: (MAP_WIDTH/2)*(MAP_HEIGHT/2) pooled pixels per frame.
- clear=1:
  - Takes priority over conv_valid in the same cycle; that sample is discarded.
  - col/row/hreg reset to 0; linebuf contents are don't-care (overwritten before use).
  - The output register still completes the pool_valid already scheduled for the next edge.
- Reset mid-frame: every state element returns to its reset value immediately; the next accepted sample is treated as (row 0, col 0).
- All comparisons are unsigned on post-ReLU values; no overflow is possible after saturation.

Optional Feature:
- Macro CONV_POOL_BYPASS_EN.
- Defined:
  - Adds input port pool_bypass (1 bit, static per frame).
  - When pool_bypass=1, every accepted sample produces pool_out=q and pool_valid=1 one cycle later. Pooling state is held.
  - frame_done pulses on sample (MAP_HEIGHT-1, MAP_WIDTH-1).
- Undefined: no port; pooling is always active. Logic is identical to pool_bypass=0.

Decomposition:
- Shared package conv_pkg holds:
  - the accumulator-width function ACC_W(DATA_SIZE) = 2*DATA_SIZE+5;
  - the saturation constant;
  - a requant function (ReLU, shift, saturate), reusable by future multi-kernel stages.
- One sub-module is natural: conv_requant (combinational/optionally registered ReLU+shift+saturate).
- Line buffer and counters stay in the top level.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with conv_valid=0 for 10 cycles -> pool_out=0, pool_valid=0, frame_done=0 throughout.
- Basic pool, defaults (4x4, SHIFT=4), inputs 16*k for k=0..15 back-to-back -> four outputs 5,7,13,15; each 1 cycle after samples 6,8,14,16 respectively; frame_done with 15.
- ReLU/saturation: block {-100, 32, 5000, -1} -> q values {0, 2, 255, 0} -> pool_out=255.
- Gapped input: same stream as the basic-pool case with random 0-3 idle cycles between samples -> identical output values and order; pool_valid never asserted on a gap-free cycle other than the cycle after a block's 4th sample.
- clear mid-frame: after 5 samples, assert clear with conv_valid=1 -> that sample is dropped; the following 16 samples produce a normal frame with 4 outputs and frame_done.
- Async reset mid-frame: rst_n low for a half-cycle after 9 samples -> outputs zero immediately; a subsequent full frame pools correctly from (0,0). With CONV_POOL_BYPASS_EN and pool_bypass=1, 16 samples produce 16 outputs of q.
